// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one execute-stage ALU between the pipeline (req0)
// and the cache/AGU (req1). It registers the ALU controls and returns tagged results.
module alu_share_arb #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req0_invA,
  input  logic             req0_invB,
  input  logic             req0_cin,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic             req1_invA,
  input  logic             req1_invB,
  input  logic             req1_cin,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ofl
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nx;
  logic   prio;
  logic   grant0, grant1;

  // On contention the requester matching prio wins; a lone requester always wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~prio);
    grant1     = req1_valid & (~req0_valid |  prio);
    req0_ready = (state == IDLE) & rst_n & grant0;
    req1_ready = (state == IDLE) & rst_n & grant1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0_ready | req1_ready) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_invA   <= 1'b0;
      alu_invB   <= 1'b0;
      alu_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_ofl    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_a    <= req0_a;
            alu_b    <= req0_b;
            alu_op   <= req0_op;
            alu_invA <= req0_invA;
            alu_invB <= req0_invB;
            alu_cin  <= req0_cin;
            rsp_id   <= 1'b0;
            prio     <= 1'b1;
          end else if (req1_ready) begin
            alu_a    <= req1_a;
            alu_b    <= req1_b;
            alu_op   <= req1_op;
            alu_invA <= req1_invA;
            alu_invB <= req1_invB;
            alu_cin  <= req1_cin;
            rsp_id   <= 1'b1;
            prio     <= 1'b0;
          end
        end
        EXEC: begin
          rsp_result <= alu_out;
          rsp_ofl    <= alu_ofl;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a behavioural ALU closes the loop, stimulus pushes
// hand-computed responses into a queue and a negedge monitor pops and compares.
module tb_alu_share_arb;

  localparam int WIDTH = 16;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_invA, req0_invB, req0_cin;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_invA, req1_invB, req1_cin;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             alu_invA, alu_invB, alu_cin, alu_ofl;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_ofl;
  logic [WIDTH-1:0] rsp_result;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_invA(req0_invA), .req0_invB(req0_invB), .req0_cin(req0_cin),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_invA(req1_invA), .req1_invB(req1_invB), .req1_cin(req1_cin),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_ofl(alu_ofl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ofl(rsp_ofl)
  );

  // Behavioural ALU: ops 0/1 add (sub via inversion + cin), 2 AND, 3 OR, 4 XOR.
  logic [WIDTH-1:0] ea, eb;
  logic [WIDTH:0]   sum;
  always_comb begin
    ea      = alu_invA ? ~alu_a : alu_a;
    eb      = alu_invB ? ~alu_b : alu_b;
    sum     = {1'b0, ea} + {1'b0, eb} + {{WIDTH{1'b0}}, alu_cin};
    alu_out = '0;
    alu_ofl = 1'b0;
    case (alu_op)
      3'd0, 3'd1: begin
        alu_out = sum[WIDTH-1:0];
        alu_ofl = (ea[WIDTH-1] == eb[WIDTH-1]) && (sum[WIDTH-1] != ea[WIDTH-1]);
      end
      3'd2: alu_out = ea & eb;
      3'd3: alu_out = ea | eb;
      3'd4: alu_out = ea ^ eb;
      default: ;
    endcase
  end

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             ofl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (req0_ready && req1_ready) chk("excl_ready", 1, 0);
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        chk("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
        chk("rsp_ofl", {31'd0, rsp_ofl}, {31'd0, e.ofl});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [OPW-1:0] op,
                         input logic ia, input logic ib, input logic c,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_invA = ia; req0_invB = ib;
      req0_cin = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_invA = ia; req1_invB = ib;
      req1_cin = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic push(input logic id, input logic [WIDTH-1:0] res, input logic ofl);
    exp_t e;
    e.id = id; e.res = res; e.ofl = ofl;
    exp_q.push_back(e);
  endtask

  // Waits for a ready pulse, checks which requester got it, returns after the handshake edge.
  task automatic wait_grant(input string name, input logic exp_id, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) begin
        chk(name, {31'd0, req1_ready}, {31'd0, exp_id});
        tick();
        return;
      end
    end
    chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic drain;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222);
    set_req(1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h4444);
    tick(); tick();

    // Reset state; ready gated while rst_n is low even with both valid.
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_alu_a", {16'd0, alu_a}, 0);
    chk("rst_rsp_result", {16'd0, rsp_result}, 0);
    tick();

    // Test 1: req0 ADD 5+3, latency check.
    set_req(1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0003);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req0_ready", {31'd0, req0_ready}, 1);
    push(1'b0, 16'h0008, 1'b0);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_alu_a", {16'd0, alu_a}, 32'h5);
    chk("t1_alu_b", {16'd0, alu_b}, 32'h3);
    chk("t1_rsp_valid_exec", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 1);
    chk("t1_rsp_result", {16'd0, rsp_result}, 32'h8);
    tick();
    drain();

    // Test 2: both valid continuously from reset -> 0,1,0,1 every 3 cycles.
    rst_n = 1'b0;
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0002);
    set_req(1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0020);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant("t2_grant", i[0], n);
      if (i[0]) push(1'b1, 16'h0030, 1'b0);
      else      push(1'b0, 16'h0003, 1'b0);
      if (i > 0) chk("t2_interval", n, 3);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Test 3: stall in RESP for 5 cycles while both requesters wait.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0001);
    wait_grant("t3_grant0", 1'b0, n);
    push(1'b0, 16'h1235, 1'b0);
    set_req(0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 16'hF0F0, 16'hFF00);
    set_req(1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0F0F);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("t3_rsp_result", {16'd0, rsp_result}, 32'h1235);
      chk("t3_rsp_id", {31'd0, rsp_id}, 0);
      chk("t3_ready_both", {30'd0, req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1'b1;
    wait_grant("t3_grant1", 1'b1, n);
    chk("t3_resume_delay", n, 2);
    push(1'b1, 16'h0FF0, 1'b0);
    req1_valid = 1'b0;
    wait_grant("t3_grant0b", 1'b0, n);
    chk("t3_interval", n, 3);
    push(1'b0, 16'hF000, 1'b0);
    req0_valid = 1'b0;
    drain();

    // Test 4: req1 alone, back-to-back, four ops.
    set_req(1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0023);
    wait_grant("t4_grant", 1'b1, n);
    push(1'b1, 16'h0123, 1'b0);
    set_req(1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 16'h00F0, 16'h000F);
    wait_grant("t4_grant", 1'b1, n);
    chk("t4_interval", n, 3);
    push(1'b1, 16'h00FF, 1'b0);
    set_req(1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 16'h0050, 16'h0010);
    wait_grant("t4_grant", 1'b1, n);
    push(1'b1, 16'h0040, 1'b0);
    set_req(1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    wait_grant("t4_grant", 1'b1, n);
    push(1'b1, 16'h8000, 1'b1);
    req1_valid = 1'b0;
    drain();

    // Test 5: reset during EXEC aborts the op and clears prio.
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0002, 16'h0002);
    wait_grant("t5_grant", 1'b0, n);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("t5_alu_a", {16'd0, alu_a}, 0);
    chk("t5_alu_b", {16'd0, alu_b}, 0);
    tick();
    set_req(0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0AAA, 16'h0111);
    set_req(1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h000A);
    rst_n = 1'b1;
    wait_grant("t5_grant_after_rst", 1'b0, n);
    chk("t5_first_cycle", n, 1);
    push(1'b0, 16'h0BBB, 1'b0);
    req0_valid = 1'b0;

    // Test 6: req1 subtract via invA+cin: ~3 + 10 + 1 = 7.
    wait_grant("t6_grant", 1'b1, n);
    push(1'b1, 16'h0007, 1'b0);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t6_alu_invA", {31'd0, alu_invA}, 1);
    chk("t6_alu_cin", {31'd0, alu_cin}, 1);
    chk("t6_alu_op", {29'd0, alu_op}, 1);
    tick();
    drain();

    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
